rv32i_mc_ctrl: RTL and testbench

- Multi-cycle control sequencer for the RV32I core datapath.
- Latches the instruction word, classifies it by opcode, and steps the shared datapath through FETCH/DECODE/EXEC/MEM/WB.
- Drives PC, IR, register-file and memory handshake controls.
- Detects illegal instructions, ECALL/EBREAK and memory timeouts; halts in TRAP.

---
 rtl/rv32i_pkg.sv | 53 +++++
 rtl/rv32i_alu_decode.sv | 37 +++
 rtl/rv32i_mc_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_rv32i_mc_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// Shared encodings for the RV32I multi-cycle controller: opcodes, FSM states,
// datapath mux/ALU codes and trap causes.
package rv32i_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
  } state_t;

  localparam logic [1:0] PC_PLUS4 = 2'd0;
  localparam logic [1:0] PC_IMM   = 2'd1;
  localparam logic [1:0] PC_ALU   = 2'd2;

  localparam logic [1:0] WB_ALU  = 2'd0;
  localparam logic [1:0] WB_LOAD = 2'd1;
  localparam logic [1:0] WB_PC4  = 2'd2;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_SLL   = 4'd2;
  localparam logic [3:0] ALU_SLT   = 4'd3;
  localparam logic [3:0] ALU_SLTU  = 4'd4;
  localparam logic [3:0] ALU_XOR   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_SRA   = 4'd7;
  localparam logic [3:0] ALU_OR    = 4'd8;
  localparam logic [3:0] ALU_AND   = 4'd9;
  localparam logic [3:0] ALU_PASSB = 4'd10;

  localparam logic [2:0] TRAP_NONE    = 3'd0;
  localparam logic [2:0] TRAP_ILLEGAL = 3'd1;
  localparam logic [2:0] TRAP_IMEM_TO = 3'd2;
  localparam logic [2:0] TRAP_DMEM_TO = 3'd3;
  localparam logic [2:0] TRAP_ECALL   = 3'd4;
  localparam logic [2:0] TRAP_EBREAK  = 3'd5;

  function automatic logic known_opcode(input logic [6:0] opc);
    return opc inside {OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD,
                       OPC_STORE, OPC_OPIMM, OPC_OP, OPC_FENCE, OPC_SYSTEM};
  endfunction

endpackage

// File: rtl/rv32i_alu_decode.sv
// Combinational opcode/funct3/funct7[5] -> ALU operation; zero latency, no handshake.
module rv32i_alu_decode
  import rv32i_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_b5,
  output logic [3:0] alu_ctrl
);

  logic [3:0] f3_op;

  always_comb begin
    f3_op = ALU_ADD;
    case (funct3)
      3'b000:  f3_op = ALU_ADD;
      3'b001:  f3_op = ALU_SLL;
      3'b010:  f3_op = ALU_SLT;
      3'b011:  f3_op = ALU_SLTU;
      3'b100:  f3_op = ALU_XOR;
      3'b101:  f3_op = funct7_b5 ? ALU_SRA : ALU_SRL;
      3'b110:  f3_op = ALU_OR;
      default: f3_op = ALU_AND;
    endcase

    // Address generation and link computations all reduce to an add.
    alu_ctrl = ALU_ADD;
    case (opcode)
      OPC_OP:     alu_ctrl = (funct3 == 3'b000 && funct7_b5) ? ALU_SUB : f3_op;
      OPC_OPIMM:  alu_ctrl = f3_op;
      OPC_LUI:    alu_ctrl = ALU_PASSB;
      OPC_BRANCH: alu_ctrl = ALU_SUB;
      default:    alu_ctrl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/rv32i_mc_ctrl.sv
// Multi-cycle RV32I sequencer: FETCH/DECODE/EXEC/MEM/WB, 3-5 cycles per instruction plus
// memory wait states; imem/dmem requests hold until ack or MEM_TIMEOUT cycles, then trap.
module rv32i_mc_ctrl
  import rv32i_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [31:0]      inst,
  input  logic             imem_ack,
  input  logic             dmem_ack,
  input  logic             br_taken,
  output logic             imem_req,
  output logic             ir_we,
  output logic             pc_we,
  output logic [1:0]       pc_sel,
  output logic             rf_we,
  output logic [1:0]       wb_sel,
  output logic [3:0]       alu_ctrl,
  output logic             alu_src_a,
  output logic             alu_src_b,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             halted,
  output logic [2:0]       trap_cause,
  output logic             retire,
  output logic [CNT_W-1:0] instret
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(MEM_TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [31:0]       ir_q;
  logic [WAIT_W-1:0] wcnt_q;
  logic [2:0]        cause_q, cause_d;
  logic [CNT_W-1:0]  instret_q;
  logic [3:0]        alu_op;

  logic [6:0]  opc;
  logic [4:0]  rd, rs1;
  logic [2:0]  f3;
  logic [11:0] imm12;
  logic        sys_base, is_ecall, is_ebreak, illegal;

  assign opc   = ir_q[6:0];
  assign rd    = ir_q[11:7];
  assign f3    = ir_q[14:12];
  assign rs1   = ir_q[19:15];
  assign imm12 = ir_q[31:20];

  // ECALL/EBREAK are the only SYSTEM encodings this core accepts.
  assign sys_base  = (opc == OPC_SYSTEM) && (f3 == 3'd0) && (rs1 == 5'd0) && (rd == 5'd0);
  assign is_ecall  = sys_base && (imm12 == 12'd0);
  assign is_ebreak = sys_base && (imm12 == 12'd1);
  assign illegal   = !known_opcode(opc) || ((opc == OPC_SYSTEM) && !is_ecall && !is_ebreak);

  rv32i_alu_decode u_alu_decode (
    .opcode    (opc),
    .funct3    (f3),
    .funct7_b5 (ir_q[30]),
    .alu_ctrl  (alu_op)
  );

  assign trap_cause = cause_q;
  assign instret    = instret_q;

  always_comb begin
    state_d   = state_q;
    cause_d   = cause_q;
    imem_req  = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_sel    = PC_PLUS4;
    rf_we     = 1'b0;
    wb_sel    = WB_ALU;
    alu_ctrl  = 4'd0;
    alu_src_a = 1'b0;
    alu_src_b = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    halted    = 1'b0;
    retire    = 1'b0;

    // ALU controls stay stable from EXEC through WB so the datapath result holds.
    if (state_q inside {S_EXEC, S_MEM, S_WB}) begin
      alu_ctrl  = alu_op;
      alu_src_a = (opc == OPC_AUIPC) || (opc == OPC_JAL);
      alu_src_b = !((opc == OPC_OP) || (opc == OPC_BRANCH));
    end

    case (state_q)
      S_IDLE: if (run) state_d = S_FETCH;
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_we   = 1'b1;
          state_d = S_DECODE;
        end else if (wcnt_q == WAIT_LIM) begin
          state_d = S_TRAP;
          cause_d = TRAP_IMEM_TO;
        end
      end
      S_DECODE: begin
        if (illegal) begin
          state_d = S_TRAP;
          cause_d = TRAP_ILLEGAL;
        end else if (is_ecall) begin
          state_d = S_TRAP;
          cause_d = TRAP_ECALL;
        end else if (is_ebreak) begin
          state_d = S_TRAP;
          cause_d = TRAP_EBREAK;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        case (opc)
          OPC_BRANCH: begin
            pc_we   = 1'b1;
            pc_sel  = br_taken ? PC_IMM : PC_PLUS4;
            retire  = 1'b1;
            state_d = S_FETCH;
          end
          OPC_FENCE: begin
            pc_we   = 1'b1;
            retire  = 1'b1;
            state_d = S_FETCH;
          end
          OPC_LOAD, OPC_STORE: state_d = S_MEM;
          default:             state_d = S_WB;
        endcase
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (opc == OPC_STORE);
        if (dmem_ack) begin
          if (opc == OPC_STORE) begin
            pc_we   = 1'b1;
            retire  = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (wcnt_q == WAIT_LIM) begin
          state_d = S_TRAP;
          cause_d = TRAP_DMEM_TO;
        end
      end
      S_WB: begin
        rf_we   = (rd != 5'd0);
        wb_sel  = (opc == OPC_LOAD) ? WB_LOAD :
                  (opc == OPC_JAL || opc == OPC_JALR) ? WB_PC4 : WB_ALU;
        pc_we   = 1'b1;
        pc_sel  = (opc == OPC_JAL) ? PC_IMM : (opc == OPC_JALR) ? PC_ALU : PC_PLUS4;
        retire  = 1'b1;
        state_d = run ? S_FETCH : S_IDLE;
      end
      S_TRAP:  halted = 1'b1;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      ir_q      <= '0;
      wcnt_q    <= '0;
      cause_q   <= TRAP_NONE;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      if (ir_we) ir_q <= inst;
      // Every exit from FETCH/MEM is on ack or trap, so the counter is zero on entry.
      if ((state_q == S_FETCH && !imem_ack) || (state_q == S_MEM && !dmem_ack))
        wcnt_q <= wcnt_q + 1'b1;
      else
        wcnt_q <= '0;
      if (retire) instret_q <= instret_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_rv32i_mc_ctrl.sv
// Directed and randomized bench for rv32i_mc_ctrl against an instruction-level model.
module tb_rv32i_mc_ctrl;
  import rv32i_pkg::*;

  logic        clk = 1'b0;
  logic        rst, run, imem_ack, dmem_ack, br_taken;
  logic [31:0] inst;
  logic        imem_req, ir_we, pc_we, rf_we, alu_src_a, alu_src_b;
  logic        dmem_req, dmem_we, halted, retire;
  logic [1:0]  pc_sel, wb_sel;
  logic [3:0]  alu_ctrl;
  logic [2:0]  trap_cause;
  logic [31:0] instret;

  rv32i_mc_ctrl #(.MEM_TIMEOUT(16), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .run(run), .inst(inst), .imem_ack(imem_ack),
    .dmem_ack(dmem_ack), .br_taken(br_taken), .imem_req(imem_req), .ir_we(ir_we),
    .pc_we(pc_we), .pc_sel(pc_sel), .rf_we(rf_we), .wb_sel(wb_sel),
    .alu_ctrl(alu_ctrl), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .halted(halted),
    .trap_cause(trap_cause), .retire(retire), .instret(instret)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int exp_ret = 0;
  int r_cyc, r_ireq, r_dreq, r_dwe, r_rfw, r_rfw_cyc, r_wbsel, r_pcwe, r_pcsel;
  int r_ret, r_halt_cyc, r_alu, r_irwe;
  logic [31:0] r_instret;
  logic r_to;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Instruction-level expectations: zero-wait latency, memory use, writeback and PC choice.
  function automatic void model(input logic [31:0] w, input logic bt, output int lat,
                                output bit mem, output bit st, output bit rfw,
                                output int wbs, output int pcs, output int cause);
    bit wb;
    wb = 0; mem = 0; st = 0; lat = 0; wbs = 0; pcs = 0; cause = 0;
    case (w[6:0])
      7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111: begin lat = 4; wb = 1; end
      7'b1101111: begin lat = 4; wb = 1; wbs = 2; pcs = 1; end
      7'b1100111: begin lat = 4; wb = 1; wbs = 2; pcs = 2; end
      7'b1100011: begin lat = 3; pcs = int'(bt); end
      7'b0001111: lat = 3;
      7'b0000011: begin lat = 5; mem = 1; wb = 1; wbs = 1; end
      7'b0100011: begin lat = 4; mem = 1; st = 1; end
      7'b1110011: cause = (w == 32'h00000073) ? 4 : (w == 32'h00100073) ? 5 : 1;
      default:    cause = 1;
    endcase
    rfw = wb && (w[11:7] != 5'd0);
  endfunction

  // Feeds one instruction, acking fetch after fw and data after dw wait cycles.
  task automatic run_instr(input logic [31:0] word, input int fw, input int dw,
                           input logic bt, input int maxc);
    int fc, dc;
    logic [31:0] junk;
    fc = 0; dc = 0;
    r_cyc = 0; r_ireq = 0; r_dreq = 0; r_dwe = 0; r_rfw = 0; r_rfw_cyc = 0; r_wbsel = 0;
    r_pcwe = 0; r_pcsel = 0; r_ret = 0; r_halt_cyc = 0; r_alu = 0; r_irwe = 0; r_instret = 0;
    for (int c = 1; c <= maxc; c++) begin
      @(negedge clk);
      imem_ack = imem_req && (fc == fw);
      dmem_ack = dmem_req && (dc == dw);
      junk = $urandom;
      inst = imem_ack ? word : junk;
      br_taken = bt;
      #1;
      r_cyc = c;
      if (imem_req) begin r_ireq++; fc++; end
      if (dmem_req) begin r_dreq++; dc++; end
      if (dmem_we) r_dwe++;
      if (ir_we) r_irwe++;
      if (rf_we) begin r_rfw++; r_rfw_cyc = c; r_wbsel = int'(wb_sel); end
      if (pc_we) begin r_pcwe++; r_pcsel = int'(pc_sel); end
      if (c == fw + 3) r_alu = int'(alu_ctrl);
      if (retire) begin r_ret++; r_instret = instret; end
      if (halted) begin r_halt_cyc = c; break; end
      if (retire) break;
    end
    r_to = (r_ret == 0 && r_halt_cyc == 0);
  endtask

  task automatic check_legal(input string tag, input logic [31:0] word, input int fw,
                             input int dw, input logic bt);
    int lat, wbs, pcs, cause;
    bit mem, st, rfw;
    model(word, bt, lat, mem, st, rfw, wbs, pcs, cause);
    run_instr(word, fw, dw, bt, 200);
    chk({tag, "_timeout"}, 32'(r_to), 0);
    chk({tag, "_latency"}, r_cyc, lat + fw + (mem ? dw : 0));
    chk({tag, "_imem_req"}, r_ireq, fw + 1);
    chk({tag, "_ir_we"}, r_irwe, 1);
    chk({tag, "_dmem_req"}, r_dreq, mem ? dw + 1 : 0);
    chk({tag, "_dmem_we"}, r_dwe, st ? dw + 1 : 0);
    chk({tag, "_rf_we"}, r_rfw, int'(rfw));
    if (rfw) begin
      chk({tag, "_wb_sel"}, r_wbsel, wbs);
      chk({tag, "_rf_we_cyc"}, r_rfw_cyc, r_cyc);
    end
    chk({tag, "_pc_we"}, r_pcwe, 1);
    chk({tag, "_pc_sel"}, r_pcsel, pcs);
    chk({tag, "_retire"}, r_ret, 1);
    chk({tag, "_instret"}, r_instret, exp_ret);
    exp_ret++;
  endtask

  task automatic check_trap(input string tag, input logic [31:0] word, input int fw,
                            input int dw, input int cause, input int halt_cyc,
                            input int ireq, input int dreq);
    run_instr(word, fw, dw, 1'b0, 200);
    chk({tag, "_halt_cyc"}, r_halt_cyc, halt_cyc);
    chk({tag, "_cause"}, 32'(trap_cause), cause);
    chk({tag, "_imem_req"}, r_ireq, ireq);
    chk({tag, "_dmem_req"}, r_dreq, dreq);
    chk({tag, "_retire"}, r_ret, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; run = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    exp_ret = 0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_outs"}, 32'({imem_req, ir_we, pc_we, pc_sel, rf_we, wb_sel, alu_ctrl,
                             alu_src_a, alu_src_b, dmem_req, dmem_we, halted,
                             trap_cause, retire}), 0);
    chk({tag, "_instret"}, instret, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1);
  end

  initial begin
    logic [6:0] opcs [10];
    logic [31:0] rw;
    opcs = '{7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111, 7'b1101111,
             7'b1100111, 7'b1100011, 7'b0001111, 7'b0000011, 7'b0100011};
    rst = 1'b1; run = 1'b0; inst = '0; imem_ack = 1'b0; dmem_ack = 1'b0; br_taken = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk_idle("reset");

    run = 1'b1;
    check_legal("add", 32'h002081B3, 0, 0, 1'b0);
    chk("add_rf_we_4th", r_rfw_cyc, 4);
    chk("add_alu", r_alu, 32'(ALU_ADD));
    check_legal("sub", 32'h402081B3, 0, 0, 1'b0);
    chk("sub_alu", r_alu, 32'(ALU_SUB));
    check_legal("lui", 32'h123450B7, 1, 0, 1'b0);
    chk("lui_alu", r_alu, 32'(ALU_PASSB));
    check_legal("lw_wait", 32'h0000A283, 0, 3, 1'b0);
    check_legal("beq_t", 32'h00208463, 0, 0, 1'b1);
    check_legal("beq_nt", 32'h00208463, 0, 0, 1'b0);
    check_legal("addi_x0", 32'h00100013, 0, 0, 1'b0);
    check_legal("fetch_limit", 32'h002081B3, 15, 0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      rw = $urandom;
      check_legal("rand", {rw[31:7], opcs[$urandom_range(0, 9)]},
                  $urandom_range(0, 4), $urandom_range(0, 4), 1'($urandom_range(0, 1)));
    end

    check_legal("beq_pre_idle", 32'h00208463, 0, 0, 1'b1);
    run = 1'b0;
    check_legal("add_to_idle", 32'h002081B3, 0, 0, 1'b0);
    repeat (2) begin
      @(negedge clk);
      imem_ack = 1'b0;
      #1;
      chk("idle_no_fetch", 32'({imem_req, retire, halted}), 0);
    end

    run = 1'b1;
    check_trap("ecall", 32'h00000073, 2, 0, 4, 5, 3, 0);
    do_reset();
    chk_idle("ecall_rst");
    run = 1'b1;
    check_trap("ebreak", 32'h00100073, 0, 0, 5, 3, 1, 0);
    do_reset();
    run = 1'b1;
    check_trap("illegal", 32'hFFFFFFFF, 0, 0, 1, 3, 1, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      run = ~run;
      #1;
      chk("trap_hold", 32'({halted, trap_cause, imem_req, pc_we, retire}), 32'b1_001_000);
    end
    do_reset();
    chk_idle("illegal_rst");

    run = 1'b1;
    check_trap("fetch_to", 32'h002081B3, 1000, 0, 2, 17, 16, 0);
    do_reset();
    run = 1'b1;
    check_trap("mem_to", 32'h0000A283, 0, 1000, 3, 20, 1, 16);
    do_reset();

    run = 1'b1;
    check_legal("pre_rst_add", 32'h002081B3, 0, 0, 1'b0);
    run_instr(32'h0000A283, 0, 1000, 1'b0, 5);
    chk("mid_mem_req", r_dreq, 2);
    @(negedge clk);
    rst = 1'b1; run = 1'b0; dmem_ack = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_mid_mem_dreq", 32'(dmem_req), 0);
    chk_idle("rst_mid_mem");
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_stays_idle", 32'({imem_req, dmem_req}), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
